// File: rtl/idelay_bank.sv
// idelay_bank: multi-channel, cycle-accurate programmable delay line with input-delay tap control.
// Optional feature: define IDELAY_BANK_WRAPFLAG_EN to build the per-channel sticky WRAP flags.
module idelay_bank #(
  parameter int    NCH          = 4,
  parameter int    TAPW         = 5,
  parameter string IDELAY_TYPE  = "FIXED",
  parameter int    IDELAY_VALUE = 0
) (
  input  logic                C,
  input  logic                RSTN,
  input  logic                REGRST,
  input  logic [NCH-1:0]      CE,
  input  logic [NCH-1:0]      INC,
  input  logic [NCH-1:0]      LD,
  input  logic [NCH-1:0]      LDPIPEEN,
  input  logic [NCH*TAPW-1:0] CNTVALUEIN,
  input  logic [NCH-1:0]      DATAIN,
  output logic [NCH-1:0]      DATAOUT,
  output logic [NCH*TAPW-1:0] CNTVALUEOUT,
  output logic [NCH-1:0]      WRAP
);

  localparam int              DEPTH    = 1 << TAPW;
  localparam logic [TAPW-1:0] TAP_INIT = TAPW'(IDELAY_VALUE);
  localparam logic [TAPW-1:0] TAP_MAX  = '1;

  localparam logic [1:0] MODE_FIXED         = 2'd0;
  localparam logic [1:0] MODE_VARIABLE      = 2'd1;
  localparam logic [1:0] MODE_VAR_LOAD      = 2'd2;
  localparam logic [1:0] MODE_VAR_LOAD_PIPE = 2'd3;

  localparam logic [1:0] MODE =
    (IDELAY_TYPE == "VARIABLE")      ? MODE_VARIABLE      :
    (IDELAY_TYPE == "VAR_LOAD")      ? MODE_VAR_LOAD      :
    (IDELAY_TYPE == "VAR_LOAD_PIPE") ? MODE_VAR_LOAD_PIPE : MODE_FIXED;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DEPTH-1:0] hist;
    logic [TAPW-1:0]  tap;
    logic [TAPW-1:0]  tap_nxt;
    logic [TAPW-1:0]  pipe;
    logic [TAPW-1:0]  cvin;
    logic             dout;

    assign cvin = CNTVALUEIN[k*TAPW +: TAPW];

    // Tap priority: load, then step, then hold. A step wraps modulo 2^TAPW.
    always_comb begin
      // NOTE: default assignment first so no path through the block leaves tap_nxt unassigned (no latch).
      tap_nxt = tap;
      if (MODE != MODE_FIXED) begin
        if (LD[k]) begin
          case (MODE)
            MODE_VAR_LOAD:      tap_nxt = cvin;
            MODE_VAR_LOAD_PIPE: tap_nxt = pipe;
            default:            tap_nxt = TAP_INIT;
          endcase
        end else if (CE[k]) begin
          tap_nxt = INC[k] ? tap + TAPW'(1) : tap - TAPW'(1);
        end
      end
    end

    always_ff @(posedge C or negedge RSTN) begin
      if (!RSTN) begin
        // NOTE: the history is a flop chain, not RAM, so it can and must be cleared by reset.
        hist <= '0;
        tap  <= TAP_INIT;
        pipe <= '0;
        dout <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments let dout read the pre-edge history and tap.
        hist <= {hist[DEPTH-2:0], DATAIN[k]};
        dout <= hist[tap];
        tap  <= tap_nxt;
        if (REGRST) begin
          pipe <= '0;
        end else if (LDPIPEEN[k]) begin
          pipe <= cvin;
        end
      end
    end

    assign DATAOUT[k]                   = dout;
    assign CNTVALUEOUT[k*TAPW +: TAPW] = tap;

`ifdef IDELAY_BANK_WRAPFLAG_EN
    logic wrap_q;

    // Sticky until the next load; a load wins over a same-edge wrap.
    always_ff @(posedge C or negedge RSTN) begin
      if (!RSTN) begin
        wrap_q <= 1'b0;
      end else if (MODE != MODE_FIXED) begin
        if (LD[k]) begin
          wrap_q <= 1'b0;
        end else if (CE[k] && (INC[k] ? (tap == TAP_MAX) : (tap == '0))) begin
          wrap_q <= 1'b1;
        end
      end
    end

    assign WRAP[k] = wrap_q;
`else
    assign WRAP[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_idelay_bank.sv
// Self-checking bench for idelay_bank: one instance per IDELAY_TYPE, directed scenarios
// followed by randomized traffic compared against a cycle-indexed behavioural model.
`timescale 1ns/1ps
module tb_idelay_bank;

  localparam int NCH  = 4;
  localparam int TAPW = 5;
  localparam int NI   = 4;
  localparam int NTAP = 1 << TAPW;
  localparam int HLEN = 8192;

`ifdef IDELAY_BANK_WRAPFLAG_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic regrst;
  logic [NCH-1:0]      ce   [NI];
  logic [NCH-1:0]      inc  [NI];
  logic [NCH-1:0]      ld   [NI];
  logic [NCH-1:0]      lpe  [NI];
  logic [NCH*TAPW-1:0] cvi  [NI];
  logic [NCH-1:0]      din  [NI];
  logic [NCH-1:0]      dout [NI];
  logic [NCH*TAPW-1:0] cvo  [NI];
  logic [NCH-1:0]      wrap [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: instance 0 FIXED, 1 VARIABLE, 2 VAR_LOAD, 3 VAR_LOAD_PIPE.
  int m_tap  [NI][NCH];
  int m_pipe [NI][NCH];
  bit m_wrap [NI][NCH];
  bit m_dout [NI][NCH];
  bit m_in   [NI][NCH][HLEN];
  int cyc = 0;
  int vf  = 1;

  always #5 clk = ~clk;

  idelay_bank #(.NCH(NCH), .TAPW(TAPW), .IDELAY_TYPE("FIXED"), .IDELAY_VALUE(3)) u_fix (
    .C(clk), .RSTN(rst_n), .REGRST(regrst), .CE(ce[0]), .INC(inc[0]), .LD(ld[0]),
    .LDPIPEEN(lpe[0]), .CNTVALUEIN(cvi[0]), .DATAIN(din[0]), .DATAOUT(dout[0]),
    .CNTVALUEOUT(cvo[0]), .WRAP(wrap[0]));
  idelay_bank #(.NCH(NCH), .TAPW(TAPW), .IDELAY_TYPE("VARIABLE"), .IDELAY_VALUE(30)) u_var (
    .C(clk), .RSTN(rst_n), .REGRST(regrst), .CE(ce[1]), .INC(inc[1]), .LD(ld[1]),
    .LDPIPEEN(lpe[1]), .CNTVALUEIN(cvi[1]), .DATAIN(din[1]), .DATAOUT(dout[1]),
    .CNTVALUEOUT(cvo[1]), .WRAP(wrap[1]));
  idelay_bank #(.NCH(NCH), .TAPW(TAPW), .IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(4)) u_vld (
    .C(clk), .RSTN(rst_n), .REGRST(regrst), .CE(ce[2]), .INC(inc[2]), .LD(ld[2]),
    .LDPIPEEN(lpe[2]), .CNTVALUEIN(cvi[2]), .DATAIN(din[2]), .DATAOUT(dout[2]),
    .CNTVALUEOUT(cvo[2]), .WRAP(wrap[2]));
  idelay_bank #(.NCH(NCH), .TAPW(TAPW), .IDELAY_TYPE("VAR_LOAD_PIPE"), .IDELAY_VALUE(2)) u_vlp (
    .C(clk), .RSTN(rst_n), .REGRST(regrst), .CE(ce[3]), .INC(inc[3]), .LD(ld[3]),
    .LDPIPEEN(lpe[3]), .CNTVALUEIN(cvi[3]), .DATAIN(din[3]), .DATAOUT(dout[3]),
    .CNTVALUEOUT(cvo[3]), .WRAP(wrap[3]));

  function automatic int iv(input int i);
    case (i)
      0:       return 3;
      1:       return 30;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [NCH*TAPW-1:0] iv_packed(input int i);
    logic [NCH*TAPW-1:0] p;
    for (int k = 0; k < NCH; k++) p[k*TAPW +: TAPW] = TAPW'(iv(i));
    return p;
  endfunction

  task automatic clear_inputs();
    regrst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ce[i] = '0; inc[i] = '0; ld[i] = '0; lpe[i] = '0; cvi[i] = '0; din[i] = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NCH; k++) begin
        m_tap[i][k] = iv(i); m_pipe[i][k] = 0; m_wrap[i][k] = 1'b0; m_dout[i][k] = 1'b0;
      end
  endtask

  // Advance the model by one edge using the currently driven inputs, then let the DUT take the edge.
  task automatic step();
    cyc++;
    if (cyc >= HLEN) begin
      $display("FAIL history_budget: cycle %0d reached limit %0d", cyc, HLEN);
      n_fail++;
      $fatal(1, "history budget exceeded");
    end
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NCH; k++) begin
        int idx;
        int cv;
        int old_pipe;
        idx      = cyc - 1 - m_tap[i][k];
        m_dout[i][k] = (idx >= vf) ? m_in[i][k][idx] : 1'b0;
        m_in[i][k][cyc] = din[i][k];
        cv       = int'(cvi[i][k*TAPW +: TAPW]);
        old_pipe = m_pipe[i][k];
        if (i != 0) begin
          if (ld[i][k]) begin
            m_tap[i][k]  = (i == 1) ? iv(i) : (i == 2) ? cv : old_pipe;
            m_wrap[i][k] = 1'b0;
          end else if (ce[i][k]) begin
            if (inc[i][k]) begin
              if (m_tap[i][k] == NTAP - 1) m_wrap[i][k] = 1'b1;
              m_tap[i][k] = (m_tap[i][k] + 1) % NTAP;
            end else begin
              if (m_tap[i][k] == 0) m_wrap[i][k] = 1'b1;
              m_tap[i][k] = (m_tap[i][k] + NTAP - 1) % NTAP;
            end
          end
        end
        if (regrst)        m_pipe[i][k] = 0;
        else if (lpe[i][k]) m_pipe[i][k] = cv;
      end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset_edges(input int n);
    for (int j = 0; j < n; j++) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    vf    = cyc + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (dout[i] !== '0) begin
        $display("FAIL reset_dout inst%0d: got %h expected 0", i, dout[i]); n_fail++;
      end
      n_checks++;
      if (cvo[i] !== iv_packed(i)) begin
        $display("FAIL reset_tap inst%0d: got %h expected %h", i, cvo[i], iv_packed(i)); n_fail++;
      end
      n_checks++;
      if (wrap[i] !== '0) begin
        $display("FAIL reset_wrap inst%0d: got %h expected 0", i, wrap[i]); n_fail++;
      end
    end
    hold_reset_edges(2);
  endtask

  task automatic test_fixed();
    for (int t = 1; t <= 20; t++) begin
      din[0][0] = (t == 10);
      ce[0]  = NCH'($urandom); inc[0] = NCH'($urandom);
      ld[0]  = NCH'($urandom); lpe[0] = NCH'($urandom);
      cvi[0] = (NCH*TAPW)'($urandom);
      step();
      n_checks++;
      if (dout[0][0] !== (t == 14)) begin
        $display("FAIL fixed_dout t=%0d: got %b expected %b", t, dout[0][0], (t == 14)); n_fail++;
      end
      n_checks++;
      if (cvo[0] !== iv_packed(0)) begin
        $display("FAIL fixed_tap t=%0d: got %h expected %h", t, cvo[0], iv_packed(0)); n_fail++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_inc_wrap();
    int exp_tap [3] = '{31, 0, 1};
    ce[1][1] = 1'b1; inc[1][1] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      n_checks++;
      if (cvo[1][1*TAPW +: TAPW] !== TAPW'(exp_tap[j])) begin
        $display("FAIL inc_tap step%0d: got %0d expected %0d", j, cvo[1][1*TAPW +: TAPW], exp_tap[j]);
        n_fail++;
      end
    end
    clear_inputs();
    n_checks++;
    if (wrap[1] !== {2'b00, WRAP_EN, 1'b0}) begin
      $display("FAIL inc_wrap: got %b expected %b", wrap[1], {2'b00, WRAP_EN, 1'b0}); n_fail++;
    end
    for (int k = 0; k < NCH; k++) begin
      if (k == 1) continue;
      n_checks++;
      if (cvo[1][k*TAPW +: TAPW] !== TAPW'(30)) begin
        $display("FAIL inc_other ch%0d: got %0d expected 30", k, cvo[1][k*TAPW +: TAPW]); n_fail++;
      end
    end
  endtask

  task automatic test_dec_reload();
    int exp_tap [2] = '{0, 31};
    ce[1][1] = 1'b1; inc[1][1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step();
      n_checks++;
      if (cvo[1][1*TAPW +: TAPW] !== TAPW'(exp_tap[j])) begin
        $display("FAIL dec_tap step%0d: got %0d expected %0d", j, cvo[1][1*TAPW +: TAPW], exp_tap[j]);
        n_fail++;
      end
    end
    n_checks++;
    if (wrap[1][1] !== WRAP_EN) begin
      $display("FAIL dec_wrap: got %b expected %b", wrap[1][1], WRAP_EN); n_fail++;
    end
    // Load together with an increment that would wrap again: load must win.
    ld[1][1] = 1'b1; inc[1][1] = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if (cvo[1][1*TAPW +: TAPW] !== TAPW'(30)) begin
      $display("FAIL reload_tap: got %0d expected 30", cvo[1][1*TAPW +: TAPW]); n_fail++;
    end
    n_checks++;
    if (wrap[1][1] !== 1'b0) begin
      $display("FAIL reload_wrap: got %b expected 0", wrap[1][1]); n_fail++;
    end
  endtask

  task automatic test_direct_load();
    cvi[2][2*TAPW +: TAPW] = TAPW'(7);
    ld[2][2] = 1'b1;
    step();
    ld[2][2] = 1'b0;
    n_checks++;
    if (cvo[2][2*TAPW +: TAPW] !== TAPW'(7)) begin
      $display("FAIL vload_tap: got %0d expected 7", cvo[2][2*TAPW +: TAPW]); n_fail++;
    end
    for (int t = 0; t <= 12; t++) begin
      din[2][2] = (t == 0);
      step();
      n_checks++;
      if (dout[2][2] !== (t == 8)) begin
        $display("FAIL vload_dout t=%0d: got %b expected %b", t, dout[2][2], (t == 8)); n_fail++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_pipe_load();
    int exp_tap [3] = '{5, 9, 0};
    lpe[3][0] = 1'b1; cvi[3][TAPW-1:0] = TAPW'(5);
    step();
    ld[3][0] = 1'b1; lpe[3][0] = 1'b1; cvi[3][TAPW-1:0] = TAPW'(9);
    step();
    n_checks++;
    if (cvo[3][TAPW-1:0] !== TAPW'(exp_tap[0])) begin
      $display("FAIL pipe_tap0: got %0d expected %0d", cvo[3][TAPW-1:0], exp_tap[0]); n_fail++;
    end
    // Clear wins over a simultaneous pipe load; the tap takes the pre-clear pipe.
    regrst = 1'b1; ld[3][0] = 1'b1; lpe[3][0] = 1'b1; cvi[3][TAPW-1:0] = TAPW'(17);
    step();
    n_checks++;
    if (cvo[3][TAPW-1:0] !== TAPW'(exp_tap[1])) begin
      $display("FAIL pipe_tap1: got %0d expected %0d", cvo[3][TAPW-1:0], exp_tap[1]); n_fail++;
    end
    regrst = 1'b0; lpe[3][0] = 1'b0; ld[3][0] = 1'b1;
    step();
    n_checks++;
    if (cvo[3][TAPW-1:0] !== TAPW'(exp_tap[2])) begin
      $display("FAIL pipe_tap2: got %0d expected %0d", cvo[3][TAPW-1:0], exp_tap[2]); n_fail++;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    cvi[2][1*TAPW +: TAPW] = TAPW'(12);
    ld[2][1] = 1'b1;
    step();
    ld[2][1] = 1'b0;
    for (int i = 0; i < NI; i++) din[i] = '1;
    ce[1][0] = 1'b1; inc[1][0] = 1'b1;
    for (int j = 0; j < 14; j++) step();
    n_checks++;
    if (dout[2][1] !== 1'b1 || cvo[2][1*TAPW +: TAPW] !== TAPW'(12)) begin
      $display("FAIL areset_pre: got dout %b tap %0d expected dout 1 tap 12",
               dout[2][1], cvo[2][1*TAPW +: TAPW]); n_fail++;
    end
    n_checks++;
    if (wrap[1][0] !== WRAP_EN) begin
      $display("FAIL areset_prewrap: got %b expected %b", wrap[1][0], WRAP_EN); n_fail++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (dout[i] !== '0) begin
        $display("FAIL areset_dout inst%0d: got %h expected 0", i, dout[i]); n_fail++;
      end
      n_checks++;
      if (cvo[i] !== iv_packed(i)) begin
        $display("FAIL areset_tap inst%0d: got %h expected %h", i, cvo[i], iv_packed(i)); n_fail++;
      end
      n_checks++;
      if (wrap[i] !== '0) begin
        $display("FAIL areset_wrap inst%0d: got %h expected 0", i, wrap[i]); n_fail++;
      end
    end
    model_reset();
    hold_reset_edges(2);
    ce[1] = '0; inc[1] = '0;
  endtask

  task automatic test_random(input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      regrst = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NI; i++) begin
        ce[i]  = NCH'($urandom);
        inc[i] = NCH'($urandom);
        lpe[i] = NCH'($urandom);
        din[i] = NCH'($urandom);
        cvi[i] = (NCH*TAPW)'($urandom);
        for (int k = 0; k < NCH; k++) ld[i][k] = ($urandom_range(0, 7) == 0);
      end
      step();
      for (int i = 0; i < NI; i++) begin
        logic [NCH-1:0]      ed;
        logic [NCH-1:0]      ew;
        logic [NCH*TAPW-1:0] et;
        for (int k = 0; k < NCH; k++) begin
          ed[k] = m_dout[i][k];
          ew[k] = WRAP_EN & m_wrap[i][k];
          et[k*TAPW +: TAPW] = TAPW'(m_tap[i][k]);
        end
        n_checks++;
        if (dout[i] !== ed) begin
          $display("FAIL rand_dout cyc%0d inst%0d: got %h expected %h", cyc, i, dout[i], ed); n_fail++;
        end
        n_checks++;
        if (cvo[i] !== et) begin
          $display("FAIL rand_tap cyc%0d inst%0d: got %h expected %h", cyc, i, cvo[i], et); n_fail++;
        end
        n_checks++;
        if (wrap[i] !== ew) begin
          $display("FAIL rand_wrap cyc%0d inst%0d: got %h expected %h", cyc, i, wrap[i], ew); n_fail++;
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_inc_wrap();
    test_dec_reload();
    test_direct_load();
    test_pipe_load();
    test_async_reset();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
